pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Drives the pc input of the single-cycle MIPS core (main) so benches and top
//  levels no longer hand-advance pc. Start/busy/done handshake runs a program
//  from start_pc to end_pc, applies branch/jump redirects from the core, counts
//  retired instructions and aborts runaway programs with a cycle timeout.
// PARAMETERS
//  ADDR_W      32     pc / address width
//  CNT_W       16     instr_count width
//  MAX_CYCLES  1000   RUN cycles before forced DONE with timeout=1
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous, active-low reset
//  start         in   1       1-cycle pulse; honoured in IDLE/DONE only
//  abort         in   1       return to IDLE from any state
//  start_pc      in   ADDR_W  first pc, sampled with start
//  end_pc        in   ADDR_W  last pc, sampled with start
//  redirect_vld  in   1       core requests non-sequential next pc
//  redirect_pc   in   ADDR_W  target for redirect
//  pc            out  ADDR_W  pc presented to the core
//  pc_vld        out  1       pc is a live fetch this cycle
//  busy          out  1       state==RUN
//  done          out  1       level, high in DONE
//  timeout       out  1       DONE entered via MAX_CYCLES
//  instr_count   out  CNT_W   pcs issued in current run, saturating
// BEHAVIOUR
//  Reset: pc=0, pc_vld=0, busy=0, done=0, timeout=0, instr_count=0, state IDLE.
//  States IDLE -> RUN -> DONE -> (start) RUN | (abort) IDLE.
//  IDLE/DONE + start: pc<=start_pc&~3, end_q<=end_pc&~3, counters and timeout
//   cleared, done<=0, RUN; pc_vld=1 from the next cycle (1-cycle latency).
//  RUN, per cycle (priority high->low):
//   abort            -> IDLE, pc_vld=0, done=0, pc holds.
//   pc==end_q        -> count this pc, DONE, pc holds, pc_vld=0, done=1.
//   cycles==MAX_CYCLES-1 -> count this pc, DONE, timeout=1, done=1.
//   redirect_vld     -> pc<=redirect_pc&~3.
//   else             -> pc<=pc+4; wraps 0xFFFF_FFFC -> 0, no flag.
//  instr_count increments on every cycle pc_vld=1; saturates at all-ones.
//  Redirect to end_q: terminates on the following cycle (end check on issued pc).
//  start in RUN ignored. abort in IDLE no effect; in DONE clears done/timeout.
//  rst_n low mid-run: all outputs to reset values immediately (async).
//  start_pc==end_pc: exactly one pc issued, instr_count=1.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds inputs step_mode, step (1-cycle pulse). In RUN
//   with step_mode=1 pc advances and pc_vld=1 only on cycles with step=1;
//   other cycles pc holds, pc_vld=0, timeout counter frozen. abort still wins.
//  Undefined: ports absent, RUN advances every cycle.
// STRUCTURE
//  Package mips_seq_pkg: state enum {SEQ_IDLE,SEQ_RUN,SEQ_DONE}, PC_INC=4,
//   WORD_MASK (~3 at ADDR_W).
//  Sub-module seq_counter (enable, clear, saturate) instanced twice: cycle
//   timer and instr_count. FSM and pc register stay in pc_sequencer.
// TESTING
//  Reset mid-RUN at pc=0x20 -> pc=0, busy=0, instr_count=0 same cycle.
//  start_pc=0, end_pc=0x10, no redirect -> pc 0,4,8,0xC,0x10; done=1,
//   instr_count=5, timeout=0.
//  Redirect at pc=8 to 0x40, end_pc=0x44 -> pc 0,4,8,0x40,0x44; count=5.
//  end_pc unreachable, MAX_CYCLES=8 -> done=1, timeout=1, instr_count=8.
//  abort with redirect_vld on same cycle -> IDLE, pc holds, done=0;
//   start during RUN ignored.
//  SINGLE_STEP_EN, step_mode=1, step every 3rd cycle, end_pc=8 -> 3 pcs
//   issued over ~9 cycles, pc_vld high only on step cycles.

Source files
------------

// File: rtl/mips_seq_pkg.sv
// mips_seq_pkg: sequencer state encoding and pc stepping constants shared by
// pc_sequencer and its benches.
package mips_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  localparam int SEQ_ADDR_W = 32;
  localparam int PC_INC     = 4;
  localparam logic [SEQ_ADDR_W-1:0] WORD_MASK = ~SEQ_ADDR_W'(3);

endpackage

// File: rtl/seq_counter.sv
// seq_counter: up-counter with synchronous clear (priority over enable) that
// sticks at all-ones instead of wrapping.
module seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: walks the MIPS core pc from start_pc to end_pc with redirects,
// a retired-instruction count and a cycle timeout. SINGLE_STEP_EN adds step gating.
module pc_sequencer
  import mips_seq_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] end_pc,
  input  logic              redirect_vld,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              pc_vld,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int TMR_W = $clog2(MAX_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(MAX_CYCLES - 1);
  // Rebuild the word mask at ADDR_W from the package's low-bit pattern.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(~WORD_MASK);

  seq_state_e        state;
  logic [ADDR_W-1:0] end_q;
  logic [TMR_W-1:0]  cyc_count;
  logic              live;
  logic              accept_start;
  logic              cyc_last;

  assign busy = (state == SEQ_RUN);

`ifdef SINGLE_STEP_EN
  assign live = busy && (!step_mode || step);
`else
  assign live = busy;
`endif

  assign pc_vld       = live;
  assign accept_start = ((state == SEQ_IDLE) || (state == SEQ_DONE)) && start && !abort;
  assign cyc_last     = (cyc_count == TMR_LAST);

  seq_counter #(.W(TMR_W)) u_cycle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept_start),
    .enable (live),
    .count  (cyc_count)
  );

  seq_counter #(.W(CNT_W)) u_instr_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept_start),
    .enable (live),
    .count  (instr_count)
  );

  // End and timeout checks act on the pc being issued this cycle, so the
  // terminating pc is counted before the sequencer parks in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEQ_IDLE;
      pc      <= '0;
      end_q   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE, SEQ_DONE: begin
          if (abort) begin
            state   <= SEQ_IDLE;
            done    <= 1'b0;
            timeout <= 1'b0;
          end else if (start) begin
            state   <= SEQ_RUN;
            pc      <= start_pc & ALIGN_MASK;
            end_q   <= end_pc & ALIGN_MASK;
            done    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        SEQ_RUN: begin
          if (abort) begin
            state <= SEQ_IDLE;
            done  <= 1'b0;
          end else if (live) begin
            if (pc == end_q) begin
              state <= SEQ_DONE;
              done  <= 1'b1;
            end else if (cyc_last) begin
              state   <= SEQ_DONE;
              done    <= 1'b1;
              timeout <= 1'b1;
            end else if (redirect_vld) begin
              pc <= redirect_pc & ALIGN_MASK;
            end else begin
              pc <= pc + ADDR_W'(PC_INC);
            end
          end
        end
        default: begin
          state <= SEQ_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed runs of pc_sequencer against a
// queue-based program model; a monitor checks every issued pc and run result.
module tb_pc_sequencer;

  localparam int MAX_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] start_pc = '0;
  logic [31:0] end_pc = '0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef SINGLE_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  bit          step_test = 1'b0;
`endif
  logic [31:0] pc;
  logic        pc_vld;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] instr_count;

  typedef struct {
    bit tmo;
    int cnt;
  } end_t;

  logic [31:0] exp_pc_q[$];
  end_t        exp_end_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  pc_sequencer #(.ADDR_W(32), .CNT_W(16), .MAX_CYCLES(MAX_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .start_pc     (start_pc),
    .end_pc       (end_pc),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
`ifdef SINGLE_STEP_EN
    .step_mode    (step_mode),
    .step         (step),
`endif
    .pc           (pc),
    .pc_vld       (pc_vld),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Program model: issue pcs one by one following the termination rules.
  task automatic modelRun(input logic [31:0] spc, input logic [31:0] epc, input bit r_en,
                          input logic [31:0] r_from, input logic [31:0] r_to, input int stop_at,
                          output logic [31:0] last_pc, output bit aborted);
    logic [31:0] p;
    logic [31:0] e;
    int n;
    end_t rec;
    p = spc & ~32'd3;
    e = epc & ~32'd3;
    n = 0;
    aborted = 1'b0;
    forever begin
      exp_pc_q.push_back(p);
      n++;
      last_pc = p;
      if (stop_at >= 0 && n - 1 == stop_at) begin
        aborted = 1'b1;
        break;
      end
      if (p == e || n == MAX_CYC) begin
        rec.tmo = (p != e);
        rec.cnt = n;
        exp_end_q.push_back(rec);
        break;
      end
      if (r_en && p == r_from) p = r_to & ~32'd3;
      else p = p + 32'd4;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] spc, input logic [31:0] epc, input bit r_en,
                               input logic [31:0] r_from, input logic [31:0] r_to,
                               input int ab_at, input bit poke_start);
    logic [31:0] last_pc;
    bit aborted;
    bit ended;
    modelRun(spc, epc, r_en, r_from, r_to, ab_at, last_pc, aborted);
    @(negedge clk);
    start = 1'b1;
    start_pc = spc;
    end_pc = epc;
    @(negedge clk);
    start = 1'b0;
    start_pc = $urandom;
    end_pc = $urandom;
    ended = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      redirect_vld = r_en && (pc == r_from);
      redirect_pc = r_en ? r_to : $urandom;
      start = poke_start && (i == 1);
      abort = (i == ab_at);
`ifdef SINGLE_STEP_EN
      step = step_test ? (i % 3 == 2) : 1'b0;
`endif
      @(negedge clk);
    end
    redirect_vld = 1'b0;
    start = 1'b0;
    abort = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    checkOutput("run ends", {31'b0, ended}, 32'd1);
    if (aborted) begin
      checkOutput("abort busy", {31'b0, busy}, 32'd0);
      checkOutput("abort done", {31'b0, done}, 32'd0);
      checkOutput("abort pc hold", pc, last_pc);
    end else begin
      checkOutput("run done", {31'b0, done}, 32'd1);
    end
  endtask

  initial begin : monitor
    logic done_d;
    end_t rec;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (pc_vld) begin
        if (exp_pc_q.size() == 0) checkOutput("pc_vld unexpected", {31'b0, pc_vld}, 32'd0);
        else checkOutput("pc", pc, exp_pc_q.pop_front());
      end
      if (done && !done_d) begin
        if (exp_end_q.size() == 0) begin
          checkOutput("done unexpected", {31'b0, done}, 32'd0);
        end else begin
          rec = exp_end_q.pop_front();
          checkOutput("timeout", {31'b0, timeout}, {31'b0, rec.tmo});
          checkOutput("instr_count", {16'b0, instr_count}, 32'(rec.cnt));
          checkOutput("busy at done", {31'b0, busy}, 32'd0);
        end
      end
      done_d = done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [31:0] last_pc;
    logic [31:0] spc;
    logic [31:0] epc;
    bit aborted;
    #1;
    checkOutput("reset pc", pc, 32'd0);
    checkOutput("reset pc_vld", {31'b0, pc_vld}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset timeout", {31'b0, timeout}, 32'd0);
    checkOutput("reset instr_count", {16'b0, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed runs");
    applyStimulus(32'h0, 32'h10, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    applyStimulus(32'h0, 32'h44, 1'b1, 32'h8, 32'h40, -1, 1'b0);
    applyStimulus(32'h0, 32'h100, 1'b0, 32'h0, 32'h0, -1, 1'b0);

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("done after DONE abort", {31'b0, done}, 32'd0);
    checkOutput("timeout after DONE abort", {31'b0, timeout}, 32'd0);
    checkOutput("busy after DONE abort", {31'b0, busy}, 32'd0);

    applyStimulus(32'h100, 32'h1000, 1'b1, 32'h108, 32'h300, 2, 1'b0);
    applyStimulus(32'h200, 32'h210, 1'b0, 32'h0, 32'h0, -1, 1'b1);
    applyStimulus(32'h33, 32'h31, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    applyStimulus(32'hFFFF_FFF8, 32'h4, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    applyStimulus(32'h50, 32'h58, 1'b1, 32'h50, 32'h23, -1, 1'b0);

    $display("[TB] reset during run");
    modelRun(32'h10, 32'h400, 1'b0, 32'h0, 32'h0, 4, last_pc, aborted);
    @(negedge clk);
    start = 1'b1;
    start_pc = 32'h10;
    end_pc = 32'h400;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (busy && pc == last_pc) break;
      @(negedge clk);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset pc", pc, 32'd0);
    checkOutput("async reset busy", {31'b0, busy}, 32'd0);
    checkOutput("async reset pc_vld", {31'b0, pc_vld}, 32'd0);
    checkOutput("async reset instr_count", {16'b0, instr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] random runs");
    for (int r = 0; r < 24; r++) begin
      spc = $urandom & 32'h0000_0FFF;
      epc = ((spc & ~32'd3) + 32'(4 * $urandom_range(0, 10))) | 32'($urandom_range(0, 3));
      applyStimulus(spc, epc, 1'($urandom_range(0, 1)),
                    (spc & ~32'd3) + 32'(4 * $urandom_range(0, 5)),
                    $urandom & 32'h0000_0FFF,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1, 1'b0);
    end

`ifdef SINGLE_STEP_EN
    $display("[TB] single-step run");
    step_mode = 1'b1;
    step_test = 1'b1;
    applyStimulus(32'h0, 32'h8, 1'b0, 32'h0, 32'h0, -1, 1'b0);
    step_mode = 1'b0;
    step_test = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #3;
    checkOutput("pc queue drained", 32'(exp_pc_q.size()), 32'd0);
    checkOutput("end queue drained", 32'(exp_end_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
